decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
Parametrised ID stage for the 5-stage RISC-V core, sitting between fetch and execute. It contains the register file, immediate generation and control decode, and a valid/ready output pipeline register. Over the current decode stage it adds:
- write-back-to-read bypass;
- load-use hazard detection with bubble insertion;
- a flush input and downstream backpressure;
- an illegal-opcode flag.

Parameters:
XLEN, 32, data/register width
REG_CNT, 32, architectural registers (power of 2); RAW = log2(REG_CNT)
BYPASS, 1, 1 = same-cycle WB-to-read forwarding; 0 = read old value
LOAD_USE_STALL, 1, 1 = detect load-use and insert bubble; 0 = never stall

Ports:
clk2  in  1  clock, all state on posedge
rst  in  1  asynchronous active-low reset
in_valid  in  1  instr valid from fetch
in_ready  out  1  stage accepts instr this cycle
instr  in  32  instruction word
flush  in  1  kill held/incoming instruction (branch redirect)
wb_en  in  1  register write enable from WB
wb_addr  in  RAW  write register index
wb_data  in  XLEN  write data (signed)
ex_ready  in  1  execute accepts out_* this cycle
out_valid  out  1  out_* hold a valid instruction
out_instr  out  32  registered instruction (next_IR equivalent)
out_a  out  XLEN  rs1 operand, signed
out_b  out  XLEN  rs2 operand, signed
out_imm  out  XLEN  sign-extended immediate
out_ctrl  out  8  {ALUControl[3:0], ALUSrc, MemWrite, RegWrite, ResultSrc}
out_illegal  out  1  registered: opcode/funct unsupported

Behaviour:
- Reset (rst=0, async):
  - all out_* clear to 0, out_valid=0.
  - all REG_CNT registers clear to 0.
- Register file:
  - write on posedge when wb_en && wb_addr!=0; x0 reads 0 always.
  - Read is combinational on instr[19:15]/instr[24:20] truncated to RAW bits.
  - BYPASS=1: if wb_en && wb_addr==rs && rs!=0, read returns wb_data.
- Decode (combinational, captured into out_*):
  - 0110011 R-type:
    - f3 000 with f7 0000000 → ADD 0000; with f7 0100000 → SUB 0001.
    - f3 111 → AND 0010; 110 → OR 0011; 100 → XOR 0100; 010 → SLT 0101; 001 → SLL 0110.
    - f3 101 with f7 0000000 → SRL 0111; with f7 0100000 → SRA 1000.
    - ALUSrc=0, RegWrite=1; imm=0.
  - 0010011 I-ALU: same f3 map (f7 only checked for shifts); ALUSrc=1, RegWrite=1; imm=I-type.
  - 0000011 load (f3 010): ADD, ALUSrc=1, RegWrite=1, ResultSrc=1; imm=I-type.
  - 0100011 store (f3 010): ADD, ALUSrc=1, MemWrite=1; imm=S-type.
  - Anything else: ctrl=0, imm=0, illegal=1 (still passed down as valid).
- Advance condition: adv = !out_valid || ex_ready.
- Load-use hazard (LOAD_USE_STALL=1): haz = out_valid && out_ctrl[0] && rd!=0, where rd = out_instr[11:7], and either:
  - rd==rs1 of instr, for R/I/load/store; or
  - rd==rs2 of instr, for R/store only.
- in_ready = flush || (adv && !haz).
- Posedge priority:
  1. flush: out_valid←0; incoming instr is dropped (accepted, not loaded).
  2. else if adv && haz: out_valid←0 (bubble); instr held upstream.
  3. else if adv && in_valid: load all out_*; out_valid←1.
  4. else if adv: out_valid←0.
  5. else (!adv): all out_* hold, stable.
- out_* other than out_valid are don't-care while out_valid=0, but must not X-propagate after reset.
- Latency: instr accepted at edge N appears on out_* after edge N; a load-use pair costs exactly 1 bubble.
- Simultaneous WB write to the held instr's source is not re-read; EX forwarding covers it.

Test Plan:
- Reset, then instr=0x00500093 (addi x1,x0,5), ex_ready=1 → next cycle out_valid=1, out_a=0, out_imm=5, out_ctrl=0x0A, out_illegal=0.
- instr=0xFFF00093 (addi x1,x0,-1) → out_imm=0xFFFFFFFF; instr=0x0020A223 (sw x2,4(x1)) → out_imm=4, out_ctrl=0x0C.
- wb_en=1, wb_addr=1, wb_data=0x1234 in the same cycle as instr=0x001101B3 (add x3,x2,x1):
  - BYPASS=1 → out_b=0x1234.
  - BYPASS=0 → out_b = old x1.
  - With wb_addr=0 → x0 stays 0.
- 0x0000A103 (lw x2,0(x1)) followed by 0x001101B3 → lw out with ctrl 0x0B, then one cycle with in_ready=0 and out_valid=0, then the add is issued with ctrl 0x02.
- ex_ready=0 for 3 cycles with a valid instr held → out_* unchanged, in_ready=0; flush asserted mid-stall → out_valid=0 next cycle, in_ready=1.
- instr=0x0000007F → out_illegal=1, out_ctrl=0; async rst pulse mid-stream → out_valid=0 immediately, registers read 0.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RISC-V ID stage with register file, WB bypass, load-use bubble
// and a valid/ready output register towards execute.
module decode_stage_pipe #(
   parameter int XLEN = 32,
   parameter int REG_CNT = 32,
   parameter bit BYPASS = 1'b1,
   parameter bit LOAD_USE_STALL = 1'b1,
   localparam int RAW = $clog2(REG_CNT)
) (
   input  logic            clk2,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [RAW-1:0]  wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_ready,
   output logic            out_valid,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [XLEN-1:0] out_imm,
   output logic [7:0]      out_ctrl,
   output logic            out_illegal
);
   logic [XLEN-1:0] regs [REG_CNT];
   logic [RAW-1:0]  rs1, rs2;
   logic [XLEN-1:0] rd_a, rd_b, i_imm, s_imm, imm;
   logic [6:0]      op, f7;
   logic [2:0]      f3;
   logic [4:0]      rd;
   logic [3:0]      alu;
   logic [7:0]      ctrl;
   logic            is_r, is_i, is_ld, is_st, alu_ok, legal, haz, adv;

   always_ff @(posedge clk2 or negedge rst)
      if (!rst) for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
      else if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;

   assign rs1  = instr[15 +: RAW];
   assign rs2  = instr[20 +: RAW];
   assign rd_a = (rs1 == '0) ? '0 : (BYPASS && wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
   assign rd_b = (rs2 == '0) ? '0 : (BYPASS && wb_en && wb_addr == rs2) ? wb_data : regs[rs2];

   assign op    = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign is_r  = op == 7'b0110011;
   assign is_i  = op == 7'b0010011;
   assign is_ld = op == 7'b0000011;
   assign is_st = op == 7'b0100011;
   assign i_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign s_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

   // funct7 only matters for ADD/SUB (R-type) and for the shift encodings
   always_comb begin
      alu = 4'd0;
      alu_ok = 1'b1;
      case (f3)
         3'b000: begin
            alu = (is_r && f7 == 7'h20) ? 4'd1 : 4'd0;
            alu_ok = !is_r || f7 == 7'h00 || f7 == 7'h20;
         end
         3'b111: alu = 4'd2;
         3'b110: alu = 4'd3;
         3'b100: alu = 4'd4;
         3'b010: alu = 4'd5;
         3'b001: begin
            alu = 4'd6;
            alu_ok = is_r || f7 == 7'h00;
         end
         3'b101: begin
            alu = (f7 == 7'h20) ? 4'd8 : 4'd7;
            alu_ok = f7 == 7'h00 || f7 == 7'h20;
         end
         default: alu_ok = 1'b0;
      endcase
   end

   assign legal = ((is_r || is_i) && alu_ok) || ((is_ld || is_st) && f3 == 3'b010);
   assign ctrl  = !legal ? 8'h00 : (is_r || is_i) ? {alu, is_i, 1'b0, 1'b1, 1'b0} :
                  is_ld ? 8'h0B : 8'h0C;
   assign imm   = (!legal || is_r) ? '0 : is_st ? s_imm : i_imm;

   // load-use: a load sitting in out_* whose rd feeds the incoming instr
   assign rd  = out_instr[11:7];
   assign haz = LOAD_USE_STALL && out_valid && out_ctrl[0] && rd != 5'd0 &&
                (((is_r || is_i || is_ld || is_st) && rd == instr[19:15]) ||
                 ((is_r || is_st) && rd == instr[24:20]));
   assign adv      = !out_valid || ex_ready;
   assign in_ready = flush || (adv && !haz);

   always_ff @(posedge clk2 or negedge rst)
      if (!rst) begin
         out_valid   <= 1'b0;
         out_instr   <= '0;
         out_a       <= '0;
         out_b       <= '0;
         out_imm     <= '0;
         out_ctrl    <= '0;
         out_illegal <= 1'b0;
      end else if (flush || (adv && (haz || !in_valid))) out_valid <= 1'b0;
      else if (adv) begin
         out_valid   <= 1'b1;
         out_instr   <= instr;
         out_a       <= rd_a;
         out_b       <= rd_b;
         out_imm     <= imm;
         out_ctrl    <= ctrl;
         out_illegal <= !legal;
      end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed plus random checks of two decode stages (with and
// without WB bypass) against an instruction-level reference model.
module tb_decode_stage_pipe;
   logic clk2 = 1'b0, rst = 1'b0;
   logic in_valid, flush, wb_en, ex_ready;
   logic [31:0] instr, wb_data;
   logic [4:0] wb_addr;
   logic in_ready1, out_valid1, out_illegal1, in_ready0, out_valid0, out_illegal0;
   logic [31:0] out_instr1, out_a1, out_b1, out_imm1, out_instr0, out_a0, out_b0, out_imm0;
   logic [7:0] out_ctrl1, out_ctrl0;
   int checks = 0, errors = 0;
   logic rdy_seen;

   logic m_valid, m_ill;
   logic [31:0] m_instr, m_a1, m_b1, m_a0, m_b0, m_imm;
   logic [7:0] m_ctrl;
   logic [31:0] mreg [32];

   always #5 clk2 = ~clk2;

   decode_stage_pipe dut1 (.clk2(clk2), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .instr(instr), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_ready(ex_ready), .out_valid(out_valid1), .out_instr(out_instr1), .out_a(out_a1),
      .out_b(out_b1), .out_imm(out_imm1), .out_ctrl(out_ctrl1), .out_illegal(out_illegal1));

   decode_stage_pipe #(.BYPASS(1'b0)) dut0 (.clk2(clk2), .rst(rst), .in_valid(in_valid),
      .in_ready(in_ready0), .instr(instr), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .ex_ready(ex_ready), .out_valid(out_valid0), .out_instr(out_instr0),
      .out_a(out_a0), .out_b(out_b0), .out_imm(out_imm0), .out_ctrl(out_ctrl0),
      .out_illegal(out_illegal0));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference decoder: ALU op number per funct3, -1 marks an unsupported encoding
   function automatic void ref_dec(input logic [31:0] i, output logic [7:0] c,
                                   output logic [31:0] im, output logic il);
      int op, f3, f7, alu;
      logic [31:0] iimm, simm;
      op = int'(i[6:0]);
      f3 = int'(i[14:12]);
      f7 = int'(i[31:25]);
      iimm = {{20{i[31]}}, i[31:20]};
      simm = {{20{i[31]}}, i[31:25], i[11:7]};
      c = 8'h00;
      im = 32'h0;
      il = 1'b1;
      if (op == 'h33 || op == 'h13) begin
         case (f3)
            0: alu = (op == 'h13 || f7 == 0) ? 0 : (f7 == 'h20) ? 1 : -1;
            7: alu = 2;
            6: alu = 3;
            4: alu = 4;
            2: alu = 5;
            1: alu = (op == 'h33 || f7 == 0) ? 6 : -1;
            5: alu = (f7 == 0) ? 7 : (f7 == 'h20) ? 8 : -1;
            default: alu = -1;
         endcase
         if (alu >= 0) begin
            c = 8'(alu * 16 + ((op == 'h13) ? 8 : 0) + 2);
            im = (op == 'h13) ? iimm : 32'h0;
            il = 1'b0;
         end
      end else if (op == 'h03 && f3 == 2) begin
         c = 8'h0B; im = iimm; il = 1'b0;
      end else if (op == 'h23 && f3 == 2) begin
         c = 8'h0C; im = simm; il = 1'b0;
      end
   endfunction

   function automatic logic [31:0] rdv(input logic [4:0] s, input bit byp, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
      return (s == 0) ? 32'h0 : (byp && we && wa == s) ? wd : mreg[s];
   endfunction

   task automatic model_reset();
      m_valid = 0; m_ill = 0; m_instr = 0; m_a1 = 0; m_b1 = 0; m_a0 = 0; m_b0 = 0;
      m_imm = 0; m_ctrl = 0;
      for (int k = 0; k < 32; k++) mreg[k] = 32'h0;
   endtask

   task automatic check_out();
      chk("valid_byp", out_valid1, m_valid);
      chk("valid_nobyp", out_valid0, m_valid);
      if (m_valid) begin
         chk("instr_byp", out_instr1, m_instr);   chk("instr_nobyp", out_instr0, m_instr);
         chk("a_byp", out_a1, m_a1);              chk("a_nobyp", out_a0, m_a0);
         chk("b_byp", out_b1, m_b1);              chk("b_nobyp", out_b0, m_b0);
         chk("imm_byp", out_imm1, m_imm);         chk("imm_nobyp", out_imm0, m_imm);
         chk("ctrl_byp", out_ctrl1, m_ctrl);      chk("ctrl_nobyp", out_ctrl0, m_ctrl);
         chk("ill_byp", out_illegal1, m_ill);     chk("ill_nobyp", out_illegal0, m_ill);
      end
   endtask

   task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic er);
      logic adv, haz, u1, u2, il;
      logic [4:0] rd, s1, s2;
      logic [6:0] op;
      logic [7:0] c;
      logic [31:0] im;
      in_valid = v; instr = ins; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
      #1;
      op = ins[6:0]; rd = m_instr[11:7]; s1 = ins[19:15]; s2 = ins[24:20];
      u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23};
      u2 = op inside {7'h33, 7'h23};
      haz = m_valid && m_ctrl[0] && rd != 0 && ((u1 && rd == s1) || (u2 && rd == s2));
      adv = !m_valid || er;
      rdy_seen = in_ready1;
      chk("in_ready_byp", in_ready1, fl || (adv && !haz));
      chk("in_ready_nobyp", in_ready0, fl || (adv && !haz));
      @(posedge clk2);
      if (fl) m_valid = 0;
      else if (adv && haz) m_valid = 0;
      else if (adv && v) begin
         ref_dec(ins, c, im, il);
         m_valid = 1; m_instr = ins; m_imm = im; m_ctrl = c; m_ill = il;
         m_a1 = rdv(s1, 1, we, wa, wd); m_b1 = rdv(s2, 1, we, wa, wd);
         m_a0 = rdv(s1, 0, we, wa, wd); m_b0 = rdv(s2, 0, we, wa, wd);
      end else if (adv) m_valid = 0;
      if (we && wa != 0) mreg[wa] = wd;
      #1;
      check_out();
   endtask

   function automatic logic [31:0] rnd_instr();
      int lst[7] = '{0, 1, 2, 4, 5, 6, 7};
      logic [4:0] rd, r1, r2;
      logic [2:0] f3;
      logic [11:0] im;
      rd = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
      f3 = 3'(lst[$urandom_range(0, 6)]);
      im = 12'($urandom);
      case ($urandom_range(0, 9))
         0, 1, 2: return {((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                          r2, r1, f3, rd, 7'h33};
         3, 4: begin
            if (f3 == 1) im[11:5] = 7'h00;
            if (f3 == 5) im[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return {im, r1, f3, rd, 7'h13};
         end
         5, 6: return {im, r1, 3'b010, rd, 7'h03};
         7: return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
         8: return {7'h00, r2, r1, 3'b011, rd, 7'h33};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      in_valid = 0; instr = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 1;
      model_reset();
      #2;
      chk("rst_valid", out_valid1, 0); chk("rst_instr", out_instr1, 0);
      chk("rst_ctrl", out_ctrl1, 0);   chk("rst_a", out_a1, 0);
      #10 rst = 1;
      cyc(1, 32'h00500093, 0, 0, 0, 0, 1);
      chk("addi_valid", out_valid1, 1); chk("addi_a", out_a1, 0); chk("addi_imm", out_imm1, 5);
      chk("addi_ctrl", out_ctrl1, 8'h0A); chk("addi_ill", out_illegal1, 0);
      cyc(1, 32'hFFF00093, 0, 0, 0, 0, 1);
      chk("addi_neg_imm", out_imm1, 32'hFFFFFFFF);
      cyc(1, 32'h0020A223, 0, 0, 0, 0, 1);
      chk("sw_imm", out_imm1, 4); chk("sw_ctrl", out_ctrl1, 8'h0C);
      cyc(1, 32'h001101B3, 0, 1, 1, 32'h1234, 1);
      chk("bypass_b", out_b1, 32'h1234); chk("nobypass_b", out_b0, 0);
      cyc(1, 32'h000001B3, 0, 1, 0, 32'hDEAD, 1);
      chk("x0_a", out_a1, 0); chk("x0_b", out_b1, 0);
      cyc(1, 32'h000001B3, 0, 0, 0, 0, 1);
      chk("x0_b_later", out_b0, 0);
      cyc(1, 32'h0000A103, 0, 0, 0, 0, 1);
      chk("lw_ctrl", out_ctrl1, 8'h0B);
      cyc(1, 32'h001101B3, 0, 0, 0, 0, 1);
      chk("lu_ready", rdy_seen, 0); chk("lu_bubble", out_valid1, 0);
      cyc(1, 32'h001101B3, 0, 0, 0, 0, 1);
      chk("lu_ready_after", rdy_seen, 1); chk("lu_add_ctrl", out_ctrl1, 8'h02);
      chk("lu_add_valid", out_valid1, 1);
      cyc(1, 32'h00500093, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 32'hFFF00093, 0, 0, 0, 0, 0);
         chk("stall_ready", rdy_seen, 0); chk("stall_imm", out_imm1, 5);
         chk("stall_valid", out_valid1, 1);
      end
      cyc(1, 32'hFFF00093, 1, 0, 0, 0, 0);
      chk("flush_ready", rdy_seen, 1); chk("flush_valid", out_valid1, 0);
      cyc(1, 32'h0000007F, 0, 0, 0, 0, 1);
      chk("illegal_flag", out_illegal1, 1); chk("illegal_ctrl", out_ctrl1, 0);
      chk("illegal_valid", out_valid1, 1);
      rst = 0;
      model_reset();
      #2;
      chk("arst_valid_byp", out_valid1, 0); chk("arst_valid_nobyp", out_valid0, 0);
      #2 rst = 1;
      cyc(1, 32'h001101B3, 0, 0, 0, 0, 1);
      chk("arst_reg_a", out_a1, 0); chk("arst_reg_b", out_b1, 0);
      for (int k = 0; k < 600; k++)
         cyc(1'($urandom_range(0, 3) != 0), rnd_instr(), 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 3) != 0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
